wb_trace_uart: RTL and testbench
================================

Name: wb_trace_uart

Overview:
- Consumes the pipeline's write-back stage output: write enable, destination register and the write-back data value.
- Every architectural register write to a register other than $0 is captured into a trace FIFO.
- Each captured write is serialised as a fixed frame over a UART 8N1 line, so the pipeline can be observed on hardware without a logic analyser.
- Sits beside the register file, fed by the MEM/WB latch outputs and the write-back data mux.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, minimum 2.
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz clock, 115200 baud); minimum 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- wb_regwrite  in  1  write-back RegWrite.
- wb_dest  in  5  write-back destination register.
- wb_data  in  32  write-back data value.
- tx  out  1  UART serial output; idle high.
- busy  out  1  high while a frame is being transmitted.
- overflow  out  1  sticky flag: at least one event was dropped.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, rst_n=0): tx=1, busy=0, overflow=0, level=0.
  - FIFO pointers cleared; serializer returns to IDLE.
  - Reset mid-frame aborts the frame; tx is forced high immediately.
- Capture:
  - Push on the rising edge where wb_regwrite=1 and wb_dest!=0.
  - Entry is {wb_dest, wb_data}, 37 bits.
  - wb_dest=0 or wb_regwrite=0: nothing is pushed.
- Full FIFO:
  - A push while full is dropped and overflow is set.
  - Exception: if a pop occurs in the same cycle, the push is accepted and overflow is not set.
  - overflow clears only on reset.
- Empty FIFO: no pop; the serializer stays in IDLE with tx=1.
- Simultaneous push and pop: level is unchanged; both are honoured.
- Frame format, 6 bytes, each byte LSB first:
  - 0xA5 sync byte.
  - {3'b000, dest}.
  - data[31:24], data[23:16], data[15:8], data[7:0].
- Serializer FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into the frame register, set byte_idx=0, go to START, busy=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=current byte[bit_idx] for CLKS_PER_BIT cycles per bit; after bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte_idx<5: increment byte_idx and go to START (no inter-byte gap).
    - Else: go to IDLE with busy=0.
- Latency:
  - Event captured at edge E; pop at edge E+1.
  - tx low from edge E+2 (the START state register output).
  - One frame occupies 60*CLKS_PER_BIT cycles.
  - Exactly one IDLE cycle separates back-to-back frames.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; byte_idx and bit_idx never exceed 5 and 7.

Optional Feature:
- Macro: WB_TRACE_TIMESTAMP_EN.
- Defined:
  - A free-running 16-bit cycle counter (reset 0, wraps 0xFFFF->0) is captured with each push.
  - Entries become 53 bits.
  - Frame is 8 bytes: the timestamp is appended as ts[15:8], ts[7:0] after the data bytes.
  - Frame length becomes 80*CLKS_PER_BIT cycles; the last byte_idx is 7.
- Undefined: no counter exists and the frame is exactly as above.

Decomposition:
- Package wb_trace_pkg holds:
  - SYNC_BYTE=8'hA5.
  - FRAME_BYTES, which depends on the macro.
  - State enum typedef {IDLE, START, DATA, STOP}.
  - Entry width constant.
- One sub-module: trace_fifo, a synchronous FIFO with push/pop/full/empty/level and async active-low reset.
- The serializer stays in the top module.

Test Plan:
- CLKS_PER_BIT=4; single write dest=5, data=0xDEADBEEF -> tx decodes bytes A5 05 DE AD BE EF; busy high 240 cycles; level returns to 0.
- wb_dest=0, wb_regwrite=1 -> no frame; tx stays 1; level stays 0.
- DEPTH=4; 6 consecutive writes while the first frame is active -> level saturates at 4; overflow=1; 5 frames emitted, one from the active frame and four from the FIFO entries.
- Push on the same edge as a pop with the FIFO full -> entry accepted, overflow stays 0, level unchanged.
- rst_n pulsed low during the DATA state of byte 3 -> tx=1 asynchronously; busy=0, level=0; no further frame bits.
- With WB_TRACE_TIMESTAMP_EN: two writes 10 cycles apart after reset -> timestamp fields differ by exactly 10; frame is 8 bytes.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared constants, serializer state type and frame byte selection for the write-back tracer.
// Optional feature macro: WB_TRACE_TIMESTAMP_EN (adds a 16-bit cycle stamp to entries/frames).
package wb_trace_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int unsigned TS_W = 16;
`else
    localparam int unsigned TS_W = 0;
`endif

    // Entry layout: {dest[4:0], data[31:0]} optionally followed by ts[15:0].
    localparam int unsigned ENTRY_W     = 5 + 32 + TS_W;
    localparam int unsigned FRAME_BYTES = 6 + TS_W / 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    // Byte idx of the frame that carries the given entry.
    function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                              input logic [2:0]         idx);
        logic [4:0]  dest;
        logic [31:0] data;
        logic [7:0]  b;
        dest = entry[ENTRY_W-1 -: 5];
        data = entry[ENTRY_W-6 -: 32];
        b    = SYNC_BYTE;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = {3'b000, dest};
            3'd2:    b = data[31:24];
            3'd3:    b = data[23:16];
            3'd4:    b = data[15:8];
            3'd5:    b = data[7:0];
`ifdef WB_TRACE_TIMESTAMP_EN
            3'd6:    b = entry[15:8];
            3'd7:    b = entry[7:0];
`endif
            default: b = SYNC_BYTE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous trace FIFO. A push while full is only taken when a pop happens in the same cycle.
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents need no reset since occupancy guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/wb_trace_uart.sv
// Captures register write-backs (dest != 0) into a FIFO and streams each as a UART 8N1 frame:
// A5, {000,dest}, data[31:24..7:0] (plus ts[15:8], ts[7:0] with WB_TRACE_TIMESTAMP_EN).
module wb_trace_uart
    import wb_trace_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wb_regwrite,
    input  logic [4:0]             wb_dest,
    input  logic [31:0]            wb_data,
    output logic                   tx,
    output logic                   busy,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned BaudW    = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LastByte = 3'(FRAME_BYTES - 1);

    logic               push_req, pop;
    logic [ENTRY_W-1:0] entry, fifo_rdata;
    logic               fifo_full, fifo_empty;

    state_e             state_q, state_d;
    logic [BaudW-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic [ENTRY_W-1:0] frame_q, frame_d;
    logic               tx_q, tx_d;
    logic               overflow_q, overflow_d;
    logic [7:0]         cur_byte;

    assign push_req = wb_regwrite && (wb_dest != 5'd0);

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q;

    // Free-running cycle stamp; wraps 0xFFFF -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + 16'd1;
    end

    assign entry = {wb_dest, wb_data, ts_q};
`else
    assign entry = {wb_dest, wb_data};
`endif

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_req),
        .wdata_i (entry),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // Serializer next-state; tx is registered from the current state so it lags by one cycle.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        pop        = 1'b0;
        cur_byte   = frame_byte(frame_q, byte_idx_q);
        tx_d       = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    frame_d    = fifo_rdata;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    baud_d     = '0;
                    state_d    = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_q == BaudLast) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            DATA: begin
                tx_d = cur_byte[bit_idx_q];
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            STOP: begin
                if (baud_q == BaudLast) begin
                    baud_d = '0;
                    if (byte_idx_q == LastByte) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push is dropped only when full and nothing leaves in the same cycle.
    always_comb begin
        overflow_d = overflow_q | (push_req & fifo_full & ~pop);
    end

    // Serializer and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            frame_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            frame_q    <= frame_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_wb_trace_uart.sv
// Directed bench for wb_trace_uart: a UART decoder pops expected bytes from a scoreboard queue.
module tb_wb_trace_uart;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef WB_TRACE_TIMESTAMP_EN
    localparam int FB = 8;
`else
    localparam int FB = 6;
`endif

    logic        clk;
    logic        rst_n;
    logic        wb_regwrite;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [2:0]  level;

    int n_cmp = 0;
    int n_err = 0;
    int rx_count = 0;
    logic [7:0] exp_q[$];

    wb_trace_uart #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb_regwrite (wb_regwrite),
        .wb_dest     (wb_dest),
        .wb_data     (wb_data),
        .tx          (tx),
        .busy        (busy),
        .overflow    (overflow),
        .level       (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0] cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 16'd1;
    end
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [4:0] d, input logic [31:0] v);
        exp_q.push_back(8'hA5);
        exp_q.push_back({3'b000, d});
        exp_q.push_back(v[31:24]);
        exp_q.push_back(v[23:16]);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
`ifdef WB_TRACE_TIMESTAMP_EN
        exp_q.push_back(cyc[15:8]);
        exp_q.push_back(cyc[7:0]);
`endif
    endtask

    // Called at a negedge; the write is sampled at the following posedge.
    task automatic drive(input logic we, input logic [4:0] d, input logic [31:0] v,
                         input bit accept);
        wb_regwrite = we;
        wb_dest     = d;
        wb_data     = v;
        if (accept) push_frame(d, v);
        @(negedge clk);
    endtask

    task automatic idle();
        wb_regwrite = 1'b0;
        wb_dest     = 5'd0;
        wb_data     = 32'd0;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge clk);
            n++;
        end
        repeat (3 * CPB) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    // UART 8N1 decoder sampling mid-bit on negedges.
    initial begin : uart_monitor
        logic [7:0] sh;
        bit         ok;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                ok = 1'b1;
                sh = '0;
                for (int k = 1; k <= 9 * CPB + CPB / 2; k++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        ok = 1'b0;
                        break;
                    end
                    if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2) sh[k / CPB - 1] = tx;
                end
                if (ok) begin
                    check("rx_stop_bit", tx, 1);
                    check("rx_byte_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check("rx_byte", sh, exp_q.pop_front());
                    rx_count++;
                end
            end
        end
    end

    initial begin : stimulus
        int cnt;
        int base;
        int lows;
        int highs;

        rst_n = 1'b0;
        idle();
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_level", level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single write: latency, busy width and frame contents.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        idle();
        check("t1_level_after_push", level, 1);
        check("t1_busy_before_pop", busy, 0);
        @(negedge clk);
        check("t1_busy_after_pop", busy, 1);
        check("t1_tx_still_high", tx, 1);
        check("t1_level_after_pop", level, 0);
        @(negedge clk);
        check("t1_tx_start_low", tx, 0);
        cnt = 2;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else break;
        end
        check("t1_busy_cycles", cnt, FB * 10 * CPB);
        wait_drain("t1_drain", 500);
        check("t1_rx_bytes", rx_count, FB);
        check("t1_level_end", level, 0);

        // dest 0 and regwrite 0 never push.
        drive(1'b1, 5'd0, 32'h11111111, 1'b0);
        drive(1'b1, 5'd0, 32'h22222222, 1'b0);
        drive(1'b0, 5'd7, 32'h33333333, 1'b0);
        idle();
        lows  = 0;
        highs = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) highs++;
        end
        check("t2_tx_low_samples", lows, 0);
        check("t2_busy_samples", highs, 0);
        check("t2_level", level, 0);

        // Fill while busy, then push on the same edge as the between-frames pop.
        base = rx_count;
        drive(1'b1, 5'd1, 32'h01020304, 1'b1);
        drive(1'b1, 5'd2, 32'hA0B0C0D0, 1'b1);
        drive(1'b1, 5'd3, 32'h00FF00FF, 1'b1);
        drive(1'b1, 5'd4, 32'hCAFEF00D, 1'b1);
        drive(1'b1, 5'd31, 32'h80000001, 1'b1);
        idle();
        check("t3_level_full", level, 4);
        cnt = 0;
        while (busy && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        check("t3_idle_gap_seen", busy, 0);
        check("t3_level_at_gap", level, 4);
        drive(1'b1, 5'd9, 32'h5A5A1234, 1'b1);
        idle();
        check("t3_level_push_pop", level, 4);
        check("t3_overflow_clear", overflow, 0);
        check("t3_busy_next_frame", busy, 1);
        wait_drain("t3_drain", 3000);
        check("t3_rx_bytes", rx_count - base, 6 * FB);

        // Six back-to-back writes: one goes active, four queue, one is dropped.
        base = rx_count;
        drive(1'b1, 5'd10, 32'h10101010, 1'b1);
        drive(1'b1, 5'd11, 32'h11223344, 1'b1);
        drive(1'b1, 5'd12, 32'h55667788, 1'b1);
        drive(1'b1, 5'd13, 32'h99AABBCC, 1'b1);
        drive(1'b1, 5'd14, 32'hDDEEFF00, 1'b1);
        drive(1'b1, 5'd15, 32'hFFFFFFFF, 1'b0);
        idle();
        check("t4_level_saturated", level, 4);
        check("t4_overflow_set", overflow, 1);
        wait_drain("t4_drain", 3000);
        check("t4_rx_bytes", rx_count - base, 5 * FB);
        check("t4_overflow_sticky", overflow, 1);
        check("t4_level_end", level, 0);

        // Reset during DATA of byte 3 (0x34, bits 0 and 1 are zero).
        base = rx_count;
        drive(1'b1, 5'd6, 32'h12345678, 1'b1);
        idle();
        cnt = 0;
        while (rx_count - base < 3 && cnt < 1000) begin
            @(posedge clk);
            cnt++;
        end
        check("t5_bytes_before_reset", rx_count - base, 3);
        repeat (7) @(negedge clk);
        check("t5_tx_low_before_reset", tx, 0);
        check("t5_busy_before_reset", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_tx_async", tx, 1);
        check("t5_busy_async", busy, 0);
        check("t5_level_async", level, 0);
        check("t5_overflow_async", overflow, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base  = rx_count;
        lows  = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("t5_tx_quiet", lows, 0);
        check("t5_no_more_bytes", rx_count - base, 0);
        check("t5_busy_quiet", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
